// File: rtl/rr_mux16_arbiter.sv
// Round-robin arbiter for 16 requesters feeding a two-level 4x4-to-1 data select.
// Latency: one cycle from request (IDLE) to registered grant and out_valid.
// Backpressure: out_ready low freezes grant/select/pointer while the winner keeps its request.
module rr_mux16_arbiter #(
  parameter int DATA_W = 8,
  parameter int N_REQ  = 16
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] in_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [3:0]              sel,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
  output logic                    busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       ptr;
  logic [3:0]       ptr_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [3:0]       sel_nxt;

  // Arbitration scratch: where the circular search starts and what it found.
  logic [3:0]       search_base;
  logic             win_found;
  logic [3:0]       win_idx;
  logic             handshake;

  // Datapath: unpacked lanes, per-group member select, then group select.
  logic [DATA_W-1:0] lane    [N_REQ];
  logic [DATA_W-1:0] grp_dat [4];
  logic [DATA_W-1:0] sel_dat;

  for (genvar l = 0; l < N_REQ; l++) begin : g_lane
    assign lane[l] = in_data[l*DATA_W +: DATA_W];
  end

  // First level: inside each group of four, pick the member addressed by sel[1:0].
  for (genvar g = 0; g < 4; g++) begin : g_grp
    localparam logic [1:0] GI = 2'(g);
    assign grp_dat[g] = lane[{GI, sel[1:0]}];
  end

  // Second level: pick the group addressed by sel[3:2].
  assign sel_dat = grp_dat[sel[3:2]];

  // Outputs are decoded from the state register; data is gated so idle lanes never leak.
  always_comb begin
    out_valid = (state == GRANT);
    busy      = (state == GRANT);
    out_data  = (state == GRANT) ? sel_dat : '0;
  end

  assign handshake = (state == GRANT) && out_ready;

  // Circular first-set search. In GRANT the search only matters on a handshake, where
  // the new pointer is sel+1, so start there directly to re-arbitrate in the same cycle.
  always_comb begin
    search_base = (state == GRANT) ? (sel + 4'd1) : ptr;
    win_found   = 1'b0;
    win_idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req[search_base + 4'(i)]) begin
        win_found = 1'b1;
        win_idx   = search_base + 4'(i);
      end
    end
  end

  // Next-state logic: grant on request, rotate on handshake, abort on withdrawal, else hold.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt        = GRANT;
          sel_nxt          = win_idx;
          gnt_nxt          = '0;
          gnt_nxt[win_idx] = 1'b1;
        end
      end
      GRANT: begin
        if (handshake) begin
          // Completed transfer (even if the request drops this same cycle).
          ptr_nxt = sel + 4'd1;
          if (win_found) begin
            sel_nxt          = win_idx;
            gnt_nxt          = '0;
            gnt_nxt[win_idx] = 1'b1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end else if (!req[sel]) begin
          // Requester gave up before being served: abort without moving priority.
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset; a pending word is simply dropped.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
      sel   <= sel_nxt;
    end
  end

  // Grant is either empty or a single requester.
  a_gnt_onehot0: assert property (@(posedge clock) $onehot0(gnt));

  // A grant is held exactly while in GRANT.
  a_gnt_state: assert property (@(posedge clock) ((gnt != '0) == (state == GRANT)));

  // The granted bit always matches the select index.
  a_gnt_sel: assert property (@(posedge clock) (state == GRANT) |-> gnt[sel]);

endmodule

// File: tb/tb_rr_mux16_arbiter.sv
module tb_rr_mux16_arbiter;

  localparam int DATA_W = 8;
  localparam int N_REQ  = 16;

  logic                    clock;
  logic                    resetn;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] in_data;
  logic [N_REQ-1:0]        gnt;
  logic [3:0]              sel;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic                    out_ready;
  logic                    busy;

  int n_cmp;
  int n_err;

  rr_mux16_arbiter #(.DATA_W(DATA_W), .N_REQ(N_REQ)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req       (req),
    .in_data   (in_data),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [7:0] v);
    in_data[l*DATA_W +: DATA_W] = v;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".gnt"},   32'(gnt), 32'h0);
    chk({tag, ".valid"}, 32'(out_valid), 32'h0);
    chk({tag, ".busy"},  32'(busy), 32'h0);
    chk({tag, ".data"},  32'(out_data), 32'h0);
  endtask

  task automatic chk_grant(input string tag, input int lane_i, input logic [7:0] d);
    chk({tag, ".gnt"},   32'(gnt), 32'(1) << lane_i);
    chk({tag, ".sel"},   32'(sel), 32'(lane_i));
    chk({tag, ".valid"}, 32'(out_valid), 32'h1);
    chk({tag, ".busy"},  32'(busy), 32'h1);
    chk({tag, ".data"},  32'(out_data), 32'(d));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    resetn    = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_lane(i, 8'hEE);

    // Reset and idle with no requests: nothing may leak onto out_data.
    tick();
    tick();
    resetn = 1'b1;
    chk("rst.sel", 32'(sel), 32'h0);
    chk("rst.ptr", 32'(dut.ptr), 32'h0);
    chk_idle("rst");
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_idle("idle");
    end

    // Single request on lane 5, handshake immediately, then drop.
    set_lane(5, 8'hA5);
    req       = 16'h0020;
    out_ready = 1'b1;
    tick();
    chk_grant("single", 5, 8'hA5);
    req = 16'h0000;
    tick();
    chk_idle("single_done");
    chk("single.ptr", 32'(dut.ptr), 32'h6);
    chk("single.sel_kept", 32'(sel), 32'h5);

    // Full-load rotation from ptr 0: lanes 0..15 then 0 again, no bubbles.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    for (int i = 0; i < N_REQ; i++) set_lane(i, 8'(i * 17));
    req       = 16'hFFFF;
    out_ready = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      tick();
      chk_grant("rr", k % 16, 8'((k % 16) * 17));
      chk("rr.ptr", 32'(dut.ptr), 32'(k % 16));
    end
    req = 16'h0000;
    tick();
    chk_idle("rr_done");
    chk("rr_done.ptr", 32'(dut.ptr), 32'h1);

    // Move ptr to 6 via one transfer on lane 5.
    req = 16'h0020;
    tick();
    chk_grant("to6", 5, 8'h55);
    req = 16'h0000;
    tick();
    chk("to6.ptr", 32'(dut.ptr), 32'h6);

    // Gapped requests from ptr 6: order 15, 0, 5; each drops as it is served.
    set_lane(15, 8'hF0);
    set_lane(0, 8'h0F);
    set_lane(5, 8'h55);
    req = 16'h8021;
    tick();
    chk_grant("gap15", 15, 8'hF0);
    req = 16'h0021;
    tick();
    chk_grant("gap0", 0, 8'h0F);
    req = 16'h0020;
    tick();
    chk_grant("gap5", 5, 8'h55);
    req = 16'h0000;
    tick();
    chk_idle("gap_done");
    chk("gap.ptr", 32'(dut.ptr), 32'h6);

    // Back-pressure on lane 3 for four cycles; data tracks the live lane.
    set_lane(3, 8'h33);
    req       = 16'h0008;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_grant("stall", 3, (c < 2) ? 8'h33 : 8'h3C);
      chk("stall.ptr", 32'(dut.ptr), 32'h6);
      if (c == 1) set_lane(3, 8'h3C);
    end
    out_ready = 1'b1;
    req       = 16'h0000;
    tick();
    chk_idle("stall_done");
    chk("stall_done.ptr", 32'(dut.ptr), 32'h4);

    // Withdrawal without handshake: abort, ptr unchanged.
    set_lane(9, 8'h99);
    req       = 16'h0200;
    out_ready = 1'b0;
    tick();
    chk_grant("wd", 9, 8'h99);
    req = 16'h0000;
    tick();
    chk_idle("wd_done");
    chk("wd.ptr", 32'(dut.ptr), 32'h4);

    // Reset while granted.
    set_lane(10, 8'hAA);
    req = 16'h0400;
    tick();
    chk_grant("rstg", 10, 8'hAA);
    resetn = 1'b0;
    tick();
    chk_idle("rstg_done");
    chk("rstg.sel", 32'(sel), 32'h0);
    chk("rstg.ptr", 32'(dut.ptr), 32'h0);
    resetn = 1'b1;
    req    = 16'h0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
